// File: rtl/arb_rr_8bitx2.sv
// Two-channel round-robin arbiter feeding a one-entry registered output stage.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (a over b).
module arb_rr_8bitx2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_data,
  output logic             s_sel,
  input  logic             s_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             w_can_load;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_load;

`ifdef ARB_FIXED_PRIO_EN
  assign w_gnt_a = a_valid;
  assign w_gnt_b = b_valid & ~a_valid;
`else
  logic r_last;

  // Under contention the channel that did not win last time is granted.
  assign w_gnt_a = a_valid & (~b_valid | r_last);
  assign w_gnt_b = b_valid & (~a_valid | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_load) begin
      r_last <= w_gnt_b;
    end
  end
`endif

  assign w_can_load = (r_state == ST_EMPTY) | s_ready;

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign a_ready = rst_n & w_can_load & w_gnt_a;
  assign b_ready = rst_n & w_can_load & w_gnt_b;
  assign w_load  = a_ready | b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_FULL;
      r_data  <= w_gnt_b ? b_data : a_data;
      r_sel   <= w_gnt_b;
    end else if ((r_state == ST_FULL) && s_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign s_valid = (r_state == ST_FULL);
  assign s_data  = r_data;
  assign s_sel   = r_sel;

endmodule
